// File: rtl/mem_pkg.sv
// mem_pkg: shared cpu_state codes, responder FSM encoding and wait-counter width
package mem_pkg;
  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_IN    = 2'b01;
  localparam logic [1:0] ST_CHECK = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam int CNT_W = 3;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and registered read
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= '0;
    else if (i_en) r_q <= r_mem[i_addr];
  assign o_q = r_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated RUN access FSM plus IN-mode loader and CHECK-mode readback
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_state,
  input  logic [AW-1:0] addr,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  output logic          ready,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_full,
  input  logic          chk_step,
  output logic [AW-1:0] chk_addr,
  output logic [DW-1:0] chk_data
);
  localparam logic [CNT_W-1:0] WAIT_M1 = CNT_W'(WAIT == 0 ? 0 : WAIT - 1);
  logic [1:0]       r_state, r_prev;
  logic [AW-1:0]    r_addr, r_ptr, r_chk;
  logic [DW-1:0]    r_din;
  logic             r_wr, r_full;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run, w_req, w_hold, w_in_entry, w_full, w_load, w_we, w_en;
  logic [AW-1:0]    w_ptr, w_chk, w_a;
  logic [DW-1:0]    w_d, w_q;
  assign w_run      = cpu_state == ST_RUN;
  assign w_req      = w_run & (mem_read | mem_write);
  assign w_hold     = w_run & (r_wr ? mem_write : mem_read);
  assign w_in_entry = cpu_state == ST_IN && r_prev != ST_IN;
  // Entering a mode restarts its pointer in the very first cycle, before the register catches up
  assign w_ptr      = w_in_entry ? '0 : r_ptr;
  assign w_full     = ~w_in_entry & r_full;
  assign w_chk      = (cpu_state == ST_CHECK && r_prev != ST_CHECK) ? '0 : r_chk;
  assign load_ready = cpu_state == ST_IN && !w_full && r_state == S_IDLE;
  assign w_load     = load_ready & load_valid;
  assign load_full  = w_full;
  assign chk_addr   = w_chk;
  assign chk_data   = w_q;
  assign ready      = r_state == S_ACK;
  assign dout_en    = ready & ~r_wr;
  assign dout       = dout_en ? w_q : '0;
  // Live addr in IDLE so a zero-wait read has its data ready in the ACK cycle
  assign w_a  = r_state != S_IDLE ? r_addr : cpu_state == ST_IN ? w_ptr : cpu_state == ST_CHECK ? w_chk : addr;
  assign w_we = (ready & r_wr) | w_load;
  assign w_d  = ready ? r_din : load_data;
  assign w_en = cpu_state != ST_HALT;
  mem_array #(.AW(AW), .DW(DW)) u_array (
    .clk(clk), .reset(reset), .i_en(w_en), .i_we(w_we),
    .i_addr(w_a), .i_data(w_d), .o_q(w_q)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_prev  <= ST_HALT;
      r_addr  <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_full  <= 1'b0;
      r_chk   <= '0;
    end else begin
      r_prev <= cpu_state;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= addr;
        r_din   <= din;
        r_wr    <= mem_write;
        r_cnt   <= WAIT_M1;
        r_state <= WAIT == 0 ? S_ACK : S_WAIT;
      end else if (r_state == S_WAIT) begin
        r_state <= !w_hold ? S_IDLE : r_cnt == '0 ? S_ACK : S_WAIT;
        r_cnt   <= r_cnt - 1'b1;
      end else if (r_state != S_IDLE) r_state <= S_IDLE;
      if (w_load) begin
        r_ptr  <= w_ptr + 1'b1;
        r_full <= w_ptr == '1;
      end else if (w_in_entry) begin
        r_ptr  <= '0;
        r_full <= 1'b0;
      end
      r_chk <= (cpu_state == ST_CHECK && chk_step) ? w_chk + 1'b1 : w_chk;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of load, readback, wait-stated access, abort and reset
module tb_mem_responder;
  logic       clk = 1'b0, reset = 1'b0;
  logic [1:0] cpu_state = 2'b00, cpu_state_b = 2'b00;
  logic [7:0] addr = '0, din = '0, load_data = '0, dout, chk_addr, chk_data;
  logic       mem_read = 0, mem_write = 0, load_valid = 0, chk_step = 0;
  logic       dout_en, ready, load_ready, load_full;
  logic [1:0] addr_b = '0, chk_addr_b;
  logic [7:0] din_b = '0, load_data_b = '0, dout_b, chk_data_b;
  logic       mem_read_b = 0, mem_write_b = 0, load_valid_b = 0, chk_step_b = 0;
  logic       dout_en_b, ready_b, load_ready_b, load_full_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.AW(8), .DW(8), .WAIT(1)) dut (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .dout(dout),
    .dout_en(dout_en), .ready(ready), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_full(load_full), .chk_step(chk_step),
    .chk_addr(chk_addr), .chk_data(chk_data)
  );

  mem_responder #(.AW(2), .DW(8), .WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .cpu_state(cpu_state_b), .addr(addr_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .din(din_b), .dout(dout_b),
    .dout_en(dout_en_b), .ready(ready_b), .load_valid(load_valid_b), .load_data(load_data_b),
    .load_ready(load_ready_b), .load_full(load_full_b), .chk_step(chk_step_b),
    .chk_addr(chk_addr_b), .chk_data(chk_data_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({dout, dout_en, ready, load_ready, load_full, chk_addr, chk_data} !== 28'h0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0", {dout, dout_en, ready, load_ready, load_full, chk_addr, chk_data});
    end
    total++;
    if ({dout_b, dout_en_b, ready_b, load_ready_b, load_full_b, chk_addr_b, chk_data_b} !== 22'h0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0", {dout_b, dout_en_b, ready_b, load_ready_b, load_full_b, chk_addr_b, chk_data_b});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_check;
    cpu_state = 2'b01;
    #1;
    total++;
    if ({load_ready, load_full} !== 2'b10) begin
      bad++;
      $display("FAIL in_entry got=%b exp=10", {load_ready, load_full});
    end
    load_valid = 1; load_data = 8'h11; tick();
    load_data = 8'h22; tick();
    load_data = 8'h33; tick();
    load_valid = 0;
    cpu_state = 2'b10;
    tick();
    total++;
    if ({chk_addr, chk_data} !== 16'h0011) begin
      bad++;
      $display("FAIL chk0 got=%h exp=0011", {chk_addr, chk_data});
    end
    chk_step = 1; tick(); chk_step = 0;
    total++;
    if (chk_addr !== 8'h01) begin
      bad++;
      $display("FAIL chk_step_addr got=%h exp=01", chk_addr);
    end
    tick();
    total++;
    if ({chk_addr, chk_data} !== 16'h0122) begin
      bad++;
      $display("FAIL chk1 got=%h exp=0122", {chk_addr, chk_data});
    end
    chk_step = 1; tick(); chk_step = 0; tick();
    total++;
    if ({chk_addr, chk_data} !== 16'h0233) begin
      bad++;
      $display("FAIL chk2 got=%h exp=0233", {chk_addr, chk_data});
    end
  endtask

  task automatic test_read_wait1;
    cpu_state = 2'b11; addr = 8'h02; mem_read = 1;
    tick();
    total++;
    if ({ready, dout_en, dout} !== 10'h0) begin
      bad++;
      $display("FAIL read_wait got=%h exp=000", {ready, dout_en, dout});
    end
    tick();
    total++;
    if ({ready, dout_en, dout} !== {2'b11, 8'h33}) begin
      bad++;
      $display("FAIL read_ack got=%h exp=333", {ready, dout_en, dout});
    end
    mem_read = 0;
    tick();
    total++;
    if ({ready, dout_en, dout} !== 10'h0) begin
      bad++;
      $display("FAIL read_after got=%h exp=000", {ready, dout_en, dout});
    end
  endtask

  task automatic test_write_read;
    addr = 8'h40; din = 8'hA5; mem_write = 1;
    tick(); tick();
    total++;
    if ({ready, dout_en, dout} !== 10'h200) begin
      bad++;
      $display("FAIL write_ack got=%h exp=200", {ready, dout_en, dout});
    end
    mem_write = 0; tick();
    mem_read = 1; tick(); tick();
    total++;
    if ({ready, dout_en, dout} !== {2'b11, 8'hA5}) begin
      bad++;
      $display("FAIL rd_after_wr got=%h exp=3a5", {ready, dout_en, dout});
    end
    mem_read = 0; tick();
    addr = 8'h41; din = 8'h5A; mem_read = 1; mem_write = 1;
    tick(); tick();
    total++;
    if ({ready, dout_en, dout} !== 10'h200) begin
      bad++;
      $display("FAIL both_ack got=%h exp=200", {ready, dout_en, dout});
    end
    mem_read = 0; mem_write = 0; din = 8'h00; tick();
    mem_read = 1; tick(); tick();
    total++;
    if (dout !== 8'h5A) begin
      bad++;
      $display("FAIL both_readback got=%h exp=5a", dout);
    end
    mem_read = 0; tick();
  endtask

  task automatic test_abort;
    addr = 8'h40; din = 8'hFF; mem_write = 1;
    tick();
    mem_write = 0;
    tick();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready got=%b exp=0", ready);
    end
    tick();
    mem_read = 1; tick(); tick();
    total++;
    if (dout !== 8'hA5) begin
      bad++;
      $display("FAIL abort_mem got=%h exp=a5", dout);
    end
    mem_read = 0; tick();
  endtask

  task automatic test_load_full;
    cpu_state_b = 2'b01; load_valid_b = 1;
    load_data_b = 8'hA0; tick();
    load_data_b = 8'hA1; tick();
    load_data_b = 8'hA2; tick();
    total++;
    if ({load_full_b, load_ready_b} !== 2'b01) begin
      bad++;
      $display("FAIL pre_full got=%b exp=01", {load_full_b, load_ready_b});
    end
    load_data_b = 8'hA3; tick();
    total++;
    if ({load_full_b, load_ready_b} !== 2'b10) begin
      bad++;
      $display("FAIL full got=%b exp=10", {load_full_b, load_ready_b});
    end
    load_data_b = 8'hEE; tick(); tick();
    load_valid_b = 0; cpu_state_b = 2'b10; tick();
    total++;
    if ({chk_addr_b, chk_data_b} !== {2'd0, 8'hA0}) begin
      bad++;
      $display("FAIL full_mem0 got=%h exp=0a0", {chk_addr_b, chk_data_b});
    end
    chk_step_b = 1; tick(); chk_step_b = 0; tick();
    total++;
    if ({chk_addr_b, chk_data_b} !== {2'd1, 8'hA1}) begin
      bad++;
      $display("FAIL full_mem1 got=%h exp=1a1", {chk_addr_b, chk_data_b});
    end
    cpu_state_b = 2'b11; addr_b = 2'd3; mem_read_b = 1;
    tick();
    total++;
    if ({ready_b, dout_en_b, dout_b} !== {2'b11, 8'hA3}) begin
      bad++;
      $display("FAIL wait0_ack got=%h exp=3a3", {ready_b, dout_en_b, dout_b});
    end
    tick();
    total++;
    if ({ready_b, dout_b} !== 9'h0) begin
      bad++;
      $display("FAIL wait0_idle got=%h exp=000", {ready_b, dout_b});
    end
    tick();
    total++;
    if (ready_b !== 1'b1) begin
      bad++;
      $display("FAIL wait0_reaccept got=%b exp=1", ready_b);
    end
    mem_read_b = 0; tick();
  endtask

  task automatic test_reset_mid;
    addr = 8'h02; mem_read = 1;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++;
    if ({ready, dout_en, dout} !== 10'h0) begin
      bad++;
      $display("FAIL rst_ack got=%h exp=000", {ready, dout_en, dout});
    end
    mem_read = 0; reset = 1'b1;
    tick();
    addr = 8'h40; din = 8'h77; mem_write = 1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({ready, dout_en} !== 2'b00) begin
      bad++;
      $display("FAIL rst_wait got=%b exp=00", {ready, dout_en});
    end
    tick(); tick();
    mem_write = 0; reset = 1'b1;
    tick();
    mem_read = 1; tick(); tick();
    total++;
    if ({ready, dout} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL rst_discard got=%h exp=1a5", {ready, dout});
    end
    mem_read = 0; tick();
  endtask

  initial begin
    test_reset();
    test_load_check();
    test_read_wait1();
    test_write_read();
    test_abort();
    test_load_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
